// File: rtl/nabp_swap_control.sv
// Swap handshake responder: ping-pongs two swappable instances, fetches
// per-angle accumulator parameters for the filling instance and sequences
// angles and partition iterations.
module nabp_swap_control #(
  parameter int unsigned pShAccuLength     = 16,
  parameter int unsigned pMpAccuInitLength = 16,
  parameter int unsigned pMpAccuBaseLength = 16,
  parameter int unsigned pNoOfAngles       = 180,
  parameter int unsigned pAngleLength      = 8,
  parameter int unsigned pNoOfItrs         = 4,
  parameter int unsigned pItrLength        = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         kick,
  output logic                         done,
  input  logic                         sw0_swap,
  input  logic                         sw1_swap,
  input  logic                         sw0_next_itr,
  input  logic                         sw1_next_itr,
  input  logic                         sw0_pe_en,
  input  logic                         sw1_pe_en,
  output logic                         sw0_swap_ack,
  output logic                         sw1_swap_ack,
  output logic                         sw0_next_itr_ack,
  output logic                         sw1_next_itr_ack,
  output logic [pShAccuLength-1:0]     sw0_sh_accu_base,
  output logic [pShAccuLength-1:0]     sw1_sh_accu_base,
  output logic [pMpAccuInitLength-1:0] sw0_mp_accu_init,
  output logic [pMpAccuInitLength-1:0] sw1_mp_accu_init,
  output logic [pMpAccuBaseLength-1:0] sw0_mp_accu_base,
  output logic [pMpAccuBaseLength-1:0] sw1_mp_accu_base,
  output logic                         prm_req,
  output logic [pAngleLength-1:0]      prm_angle,
  input  logic                         prm_valid,
  input  logic [pShAccuLength-1:0]     prm_sh_accu_base,
  input  logic [pMpAccuInitLength-1:0] prm_mp_accu_init,
  input  logic [pMpAccuBaseLength-1:0] prm_mp_accu_base,
  output logic                         pe_sel,
  output logic                         pe_en,
  output logic [pItrLength-1:0]        itr
);

  localparam int unsigned SCW = pAngleLength + 1;
  localparam logic [SCW-1:0] N_ANGLES = SCW'(pNoOfAngles);
  localparam logic [SCW-1:0] N_SWAPS  = SCW'(pNoOfAngles + 1);
  localparam logic [pItrLength-1:0] ITR_LAST = pItrLength'(pNoOfItrs - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SWAP, S_FETCH, S_ACK, S_NEXT_ITR, S_DONE
  } state_t;

  state_t                       state, state_d;
  logic [SCW-1:0]               swap_cnt, swap_cnt_d;
  logic                         proc_valid, proc_valid_d;
  logic                         swap_ack, swap_ack_d;
  logic                         itr_ack, itr_ack_d;
  logic [pShAccuLength-1:0]     stg_sh, stg_sh_d;
  logic [pMpAccuInitLength-1:0] stg_mi, stg_mi_d;
  logic [pMpAccuBaseLength-1:0] stg_mb, stg_mb_d;
  logic [pShAccuLength-1:0]     sw0_sh_d, sw1_sh_d;
  logic [pMpAccuInitLength-1:0] sw0_mi_d, sw1_mi_d;
  logic [pMpAccuBaseLength-1:0] sw0_mb_d, sw1_mb_d;
  logic                         done_d, prm_req_d, pe_sel_d, pe_en_d, do_swap;
  logic [pAngleLength-1:0]      prm_angle_d;
  logic [pItrLength-1:0]        itr_d;

  assign sw0_swap_ack     = swap_ack;
  assign sw1_swap_ack     = swap_ack;
  assign sw0_next_itr_ack = itr_ack;
  assign sw1_next_itr_ack = itr_ack;

  // Next-state and next-register values; swap bookkeeping lands on entry to ACK
  always_comb begin
    state_d      = state;
    swap_cnt_d   = swap_cnt;
    proc_valid_d = proc_valid;
    itr_d        = itr;
    pe_sel_d     = pe_sel;
    done_d       = done;
    prm_req_d    = prm_req;
    prm_angle_d  = prm_angle;
    stg_sh_d     = stg_sh;
    stg_mi_d     = stg_mi;
    stg_mb_d     = stg_mb;
    sw0_sh_d     = sw0_sh_accu_base;
    sw0_mi_d     = sw0_mp_accu_init;
    sw0_mb_d     = sw0_mp_accu_base;
    sw1_sh_d     = sw1_sh_accu_base;
    sw1_mi_d     = sw1_mp_accu_init;
    sw1_mb_d     = sw1_mp_accu_base;
    swap_ack_d   = 1'b0;
    itr_ack_d    = 1'b0;
    do_swap      = 1'b0;
    pe_en_d      = proc_valid && (pe_sel ? sw1_pe_en : sw0_pe_en);

    case (state)
      S_IDLE, S_DONE: begin
        if (kick) begin
          itr_d        = '0;
          swap_cnt_d   = '0;
          pe_sel_d     = 1'b0;
          proc_valid_d = 1'b0;
          done_d       = 1'b0;
          state_d      = S_WAIT_SWAP;
        end
      end
      S_WAIT_SWAP: begin
        if (sw0_swap && sw1_swap) begin
          if (swap_cnt < N_ANGLES) begin
            prm_req_d   = 1'b1;
            prm_angle_d = pAngleLength'(swap_cnt);
            state_d     = S_FETCH;
          end else begin
            // drain swap: nothing left to fetch, filler gets zeros
            stg_sh_d = '0;
            stg_mi_d = '0;
            stg_mb_d = '0;
            do_swap  = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (prm_valid) begin
          prm_req_d = 1'b0;
          stg_sh_d  = prm_sh_accu_base;
          stg_mi_d  = prm_mp_accu_init;
          stg_mb_d  = prm_mp_accu_base;
          do_swap   = 1'b1;
        end
      end
      S_ACK: begin
        state_d = (swap_cnt == N_SWAPS) ? S_NEXT_ITR : S_WAIT_SWAP;
      end
      S_NEXT_ITR: begin
        if (sw0_next_itr && sw1_next_itr) begin
          itr_ack_d = 1'b1;
          if (itr == ITR_LAST) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            itr_d        = itr + pItrLength'(1);
            swap_cnt_d   = '0;
            pe_sel_d     = 1'b0;
            proc_valid_d = 1'b0;
            state_d      = S_WAIT_SWAP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // outgoing processor becomes the filler and receives the staged params
    if (do_swap) begin
      state_d      = S_ACK;
      swap_ack_d   = 1'b1;
      pe_sel_d     = ~pe_sel;
      proc_valid_d = (swap_cnt != '0);
      swap_cnt_d   = swap_cnt + SCW'(1);
      if (pe_sel) begin
        sw1_sh_d = stg_sh_d;
        sw1_mi_d = stg_mi_d;
        sw1_mb_d = stg_mb_d;
      end else begin
        sw0_sh_d = stg_sh_d;
        sw0_mi_d = stg_mi_d;
        sw0_mb_d = stg_mb_d;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      swap_cnt         <= '0;
      proc_valid       <= 1'b0;
      itr              <= '0;
      pe_sel           <= 1'b0;
      pe_en            <= 1'b0;
      done             <= 1'b0;
      prm_req          <= 1'b0;
      prm_angle        <= '0;
      swap_ack         <= 1'b0;
      itr_ack          <= 1'b0;
      stg_sh           <= '0;
      stg_mi           <= '0;
      stg_mb           <= '0;
      sw0_sh_accu_base <= '0;
      sw0_mp_accu_init <= '0;
      sw0_mp_accu_base <= '0;
      sw1_sh_accu_base <= '0;
      sw1_mp_accu_init <= '0;
      sw1_mp_accu_base <= '0;
    end else begin
      state            <= state_d;
      swap_cnt         <= swap_cnt_d;
      proc_valid       <= proc_valid_d;
      itr              <= itr_d;
      pe_sel           <= pe_sel_d;
      pe_en            <= pe_en_d;
      done             <= done_d;
      prm_req          <= prm_req_d;
      prm_angle        <= prm_angle_d;
      swap_ack         <= swap_ack_d;
      itr_ack          <= itr_ack_d;
      stg_sh           <= stg_sh_d;
      stg_mi           <= stg_mi_d;
      stg_mb           <= stg_mb_d;
      sw0_sh_accu_base <= sw0_sh_d;
      sw0_mp_accu_init <= sw0_mi_d;
      sw0_mp_accu_base <= sw0_mb_d;
      sw1_sh_accu_base <= sw1_sh_d;
      sw1_mp_accu_init <= sw1_mi_d;
      sw1_mp_accu_base <= sw1_mb_d;
    end
  end

endmodule
